// File: rtl/nibble_serial_add_sub_pkg.sv
//------------------------------------------------------------------------------
// Module  : nibble_serial_add_sub_pkg
// Brief   : Shared constants, FSM encoding and sizing helpers for the
//           nibble-serial add/subtract unit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package nibble_serial_add_sub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nibble_count(input int width);
    return width / NIBBLE_W;
  endfunction

  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_serial_add_sub_adder_4bits.sv
//------------------------------------------------------------------------------
// Module  : adder_4bits
// Brief   : 4-bit carry-lookahead adder slice with carry in and carry out.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module adder_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Every carry is flattened to a two-level generate/propagate term.
  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

  assign s  = w_p ^ w_c[3:0];
  assign co = w_c[4];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_add_sub.sv
//------------------------------------------------------------------------------
// Module  : nibble_serial_add_sub
// Brief   : WIDTH-bit add/subtract computed one nibble per clock through a
//           single 4-bit CLA. Define NIBBLE_SERIAL_FLAGS_EN for ovf/zero flags.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module nibble_serial_add_sub
  import nibble_serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int N     = nibble_count(WIDTH);
  localparam int IDX_W = index_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               co_q, co_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
`ifdef NIBBLE_SERIAL_FLAGS_EN
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
`endif

  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_co;

  adder_4bits u_adder (
    .a  (a_q[NIBBLE_W-1:0]),
    .b  (b_q[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s  (nib_s),
    .co (nib_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    co_d    = co_q;
    idx_d   = idx_q;
`ifdef NIBBLE_SERIAL_FLAGS_EN
    ovf_d   = ovf_q;
    zero_d  = zero_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = {nib_s, acc_q[WIDTH-1:NIBBLE_W]};
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        carry_d = nib_co;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // Top nibble: a_q[3]/b_q[3] are the operand sign bits here.
          sum_d   = acc_d;
          co_d    = nib_co;
          state_d = DONE;
`ifdef NIBBLE_SERIAL_FLAGS_EN
          zero_d  = (acc_d == '0);
          ovf_d   = (a_q[NIBBLE_W-1] == b_q[NIBBLE_W-1]) &&
                    (nib_s[NIBBLE_W-1] != a_q[NIBBLE_W-1]);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      idx_q   <= '0;
`ifdef NIBBLE_SERIAL_FLAGS_EN
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      idx_q   <= idx_d;
`ifdef NIBBLE_SERIAL_FLAGS_EN
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign co        = co_q;
`ifdef NIBBLE_SERIAL_FLAGS_EN
  assign ovf       = ovf_q;
  assign zero      = zero_q;
`else
  assign ovf       = 1'b0;
  assign zero      = 1'b0;
`endif

endmodule

`default_nettype wire
